// File: rtl/branch_resolve_bht_if.sv
// Fetch/execute bundle for the branch resolve unit.
// Master is the pipeline side, slave is the resolve unit.
interface branch_resolve_bht_if #(
   parameter int PC_WIDTH   = 16,
   parameter int STAT_WIDTH = 16
);
   logic                  pred_valid;
   logic [PC_WIDTH-1:0]   pred_pc;
   logic                  pred_taken;
   logic                  res_valid;
   logic [3:0]            res_opcode;
   logic [2:0]            res_nzp;
   logic [2:0]            res_cc;
   logic [PC_WIDTH-1:0]   res_pc;
   logic                  res_pred_taken;
   logic                  flush;
   logic                  res_out_valid;
   logic                  br_taken;
   logic                  jsr_sel;
   logic                  mispredict;
   logic [STAT_WIDTH-1:0] stat_branches;
   logic [STAT_WIDTH-1:0] stat_mispredicts;

   modport master (
      output pred_valid, pred_pc, res_valid, res_opcode,
      output res_nzp, res_cc, res_pc, res_pred_taken, flush,
      input  pred_taken, res_out_valid, br_taken, jsr_sel,
      input  mispredict, stat_branches, stat_mispredicts
   );

   modport slave (
      input  pred_valid, pred_pc, res_valid, res_opcode,
      input  res_nzp, res_cc, res_pc, res_pred_taken, flush,
      output pred_taken, res_out_valid, br_taken, jsr_sel,
      output mispredict, stat_branches, stat_mispredicts
   );
endinterface

// File: rtl/branch_resolve_bht.sv
// LC-3b branch resolve stage with a direct-mapped BHT of
// saturating counters and saturating branch statistics.
module branch_resolve_bht #(
   parameter int PC_WIDTH   = 16,
   parameter int BHT_IDX    = 4,
   parameter int CTR_WIDTH  = 2,
   parameter int STAT_WIDTH = 16
) (
   input logic clk,
   input logic reset_n,
   branch_resolve_bht_if.slave bus
);
   localparam int ENTRIES = 1 << BHT_IDX;
   localparam logic [CTR_WIDTH-1:0] CTR_RST =
      CTR_WIDTH'((1 << (CTR_WIDTH - 1)) - 1);
   localparam logic [CTR_WIDTH-1:0] CTR_MAX = '1;
   localparam logic [CTR_WIDTH-1:0] CTR_ONE = CTR_WIDTH'(1);
   localparam logic [STAT_WIDTH-1:0] STAT_MAX = '1;
   localparam logic [STAT_WIDTH-1:0] STAT_ONE = STAT_WIDTH'(1);

   logic                  is_br;
   logic                  is_jsr;
   logic                  taken;
   logic                  misp;
   logic                  bht_wr;
   logic [BHT_IDX-1:0]    widx;
   logic [BHT_IDX-1:0]    ridx;
   logic [CTR_WIDTH-1:0]  ctr_old;
   logic [CTR_WIDTH-1:0]  ctr_upd;
   logic [CTR_WIDTH-1:0]  ctr_rd;
   logic [CTR_WIDTH-1:0]  bht_q [ENTRIES];

   logic                  vld_d, vld_q;
   logic                  tk_d, tk_q;
   logic                  jsr_d, jsr_q;
   logic                  mp_d, mp_q;
   logic                  pt_d, pt_q;
   logic [STAT_WIDTH-1:0] nbr_d, nbr_q;
   logic [STAT_WIDTH-1:0] nmp_d, nmp_q;

   logic                  unused_pc;

   assign widx = bus.res_pc[BHT_IDX:1];
   assign ridx = bus.pred_pc[BHT_IDX:1];
   assign unused_pc = ^{bus.res_pc[0], bus.res_pc[PC_WIDTH-1:BHT_IDX+1],
                        bus.pred_pc[0], bus.pred_pc[PC_WIDTH-1:BHT_IDX+1]};

   always_comb begin
      is_br   = bus.res_opcode == 4'b0000;
      is_jsr  = bus.res_opcode == 4'b0100 && bus.res_nzp[2];
      taken   = (is_br && |(bus.res_nzp & bus.res_cc)) || is_jsr;
      misp    = is_br && (taken != bus.res_pred_taken);
      bht_wr  = bus.res_valid && is_br;
      ctr_old = bht_q[widx];
      ctr_upd = ctr_old;
      if (taken) begin
         if (ctr_old != CTR_MAX) ctr_upd = ctr_old + CTR_ONE;
      end else if (ctr_old != '0) begin
         ctr_upd = ctr_old - CTR_ONE;
      end
      // write-first: a same-index update is visible to this prediction
      ctr_rd = (bht_wr && widx == ridx) ? ctr_upd : bht_q[ridx];

      vld_d = bus.res_valid && !bus.flush;
      tk_d  = vld_d && taken;
      jsr_d = vld_d && is_jsr;
      mp_d  = vld_d && misp;
      pt_d  = bus.pred_valid && !bus.flush && ctr_rd[CTR_WIDTH-1];

      nbr_d = nbr_q;
      if (bht_wr && nbr_q != STAT_MAX) nbr_d = nbr_q + STAT_ONE;
      nmp_d = nmp_q;
      if (bht_wr && misp && nmp_q != STAT_MAX) nmp_d = nmp_q + STAT_ONE;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < ENTRIES; i++) bht_q[i] <= CTR_RST;
         vld_q <= 1'b0;
         tk_q  <= 1'b0;
         jsr_q <= 1'b0;
         mp_q  <= 1'b0;
         pt_q  <= 1'b0;
         nbr_q <= '0;
         nmp_q <= '0;
      end else begin
         if (bht_wr) bht_q[widx] <= ctr_upd;
         vld_q <= vld_d;
         tk_q  <= tk_d;
         jsr_q <= jsr_d;
         mp_q  <= mp_d;
         pt_q  <= pt_d;
         nbr_q <= nbr_d;
         nmp_q <= nmp_d;
      end
   end

   assign bus.res_out_valid    = vld_q;
   assign bus.br_taken         = tk_q;
   assign bus.jsr_sel          = jsr_q;
   assign bus.mispredict       = mp_q;
   assign bus.pred_taken       = pt_q;
   assign bus.stat_branches    = nbr_q;
   assign bus.stat_mispredicts = nmp_q;
endmodule

// File: tb/tb_branch_resolve_bht.sv
// Directed bench for branch_resolve_bht: vector table for the
// condition matrix plus sequences for BHT, bypass, flush, stats.
module tb_branch_resolve_bht;
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   branch_resolve_bht_if #(.PC_WIDTH(16), .STAT_WIDTH(16)) b ();
   branch_resolve_bht_if #(.PC_WIDTH(16), .STAT_WIDTH(4)) b4 ();

   branch_resolve_bht #(
      .PC_WIDTH(16), .BHT_IDX(4), .CTR_WIDTH(2), .STAT_WIDTH(16)
   ) dut (
      .clk(clk), .reset_n(reset_n), .bus(b)
   );

   branch_resolve_bht #(
      .PC_WIDTH(16), .BHT_IDX(4), .CTR_WIDTH(2), .STAT_WIDTH(4)
   ) dut4 (
      .clk(clk), .reset_n(reset_n), .bus(b4)
   );

   typedef struct {
      logic [3:0] op;
      logic [2:0] nzp;
      logic [2:0] cc;
      logic       pt;
      logic [3:0] exp;   // {res_out_valid, br_taken, jsr_sel, mispredict}
   } vec_t;

   vec_t vt [19];
   int n_chk = 0;
   int n_fail = 0;
   int exp_br = 0;
   int exp_mp = 0;

   function automatic vec_t mk(logic [3:0] op, logic [2:0] nzp,
                               logic [2:0] cc, logic pt, logic [3:0] exp);
      vec_t v;
      v.op = op; v.nzp = nzp; v.cc = cc; v.pt = pt; v.exp = exp;
      return v;
   endfunction

   function automatic logic [3:0] outs();
      return {b.res_out_valid, b.br_taken, b.jsr_sel, b.mispredict};
   endfunction

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      b.pred_valid = 0; b.pred_pc = '0; b.res_valid = 0;
      b.res_opcode = '0; b.res_nzp = '0; b.res_cc = '0;
      b.res_pc = '0; b.res_pred_taken = 0; b.flush = 0;
      b4.pred_valid = 0; b4.pred_pc = '0; b4.res_valid = 0;
      b4.res_opcode = '0; b4.res_nzp = '0; b4.res_cc = '0;
      b4.res_pc = '0; b4.res_pred_taken = 0; b4.flush = 0;
   endtask

   task automatic br(logic [2:0] nzp, logic [2:0] cc,
                     logic [15:0] pc, logic pt);
      b.res_valid = 1; b.res_opcode = 4'b0000;
      b.res_nzp = nzp; b.res_cc = cc; b.res_pc = pc;
      b.res_pred_taken = pt;
      exp_br++;
      if ((|(nzp & cc)) != pt) exp_mp++;
   endtask

   task automatic predict(string nm, logic [15:0] pc, logic exp);
      b.res_valid = 0;
      b.pred_valid = 1;
      b.pred_pc = pc;
      step();
      chk(nm, 32'(b.pred_taken), 32'(exp));
      b.pred_valid = 0;
   endtask

   initial begin
      vt[0]  = mk(4'b0000, 3'b100, 3'b100, 0, 4'b1101);
      vt[1]  = mk(4'b0000, 3'b100, 3'b010, 0, 4'b1000);
      vt[2]  = mk(4'b0000, 3'b100, 3'b001, 0, 4'b1000);
      vt[3]  = mk(4'b0000, 3'b010, 3'b100, 0, 4'b1000);
      vt[4]  = mk(4'b0000, 3'b010, 3'b010, 0, 4'b1101);
      vt[5]  = mk(4'b0000, 3'b010, 3'b001, 0, 4'b1000);
      vt[6]  = mk(4'b0000, 3'b001, 3'b100, 0, 4'b1000);
      vt[7]  = mk(4'b0000, 3'b001, 3'b010, 0, 4'b1000);
      vt[8]  = mk(4'b0000, 3'b001, 3'b001, 0, 4'b1101);
      vt[9]  = mk(4'b0000, 3'b000, 3'b100, 0, 4'b1000);
      vt[10] = mk(4'b0000, 3'b000, 3'b010, 0, 4'b1000);
      vt[11] = mk(4'b0000, 3'b000, 3'b001, 0, 4'b1000);
      vt[12] = mk(4'b0000, 3'b111, 3'b100, 0, 4'b1101);
      vt[13] = mk(4'b0000, 3'b111, 3'b010, 0, 4'b1101);
      vt[14] = mk(4'b0000, 3'b111, 3'b001, 0, 4'b1101);
      vt[15] = mk(4'b0100, 3'b100, 3'b000, 0, 4'b1110);
      vt[16] = mk(4'b0100, 3'b111, 3'b010, 1, 4'b1110);
      vt[17] = mk(4'b0100, 3'b000, 3'b010, 0, 4'b1000);
      vt[18] = mk(4'b0001, 3'b111, 3'b010, 0, 4'b1000);

      idle();
      #2;
      chk("reset_outs", 32'(outs()), 0);
      chk("reset_pred", 32'(b.pred_taken), 0);
      chk("reset_nbr", 32'(b.stat_branches), 0);
      chk("reset_nmp4", 32'(b4.stat_mispredicts), 0);
      step();
      step();
      reset_n = 1;

      // result in flight, then async reset with res_valid still high
      br(3'b111, 3'b010, 16'h3004, 0);
      step();
      chk("pre_reset_outs", 32'(outs()), 32'hD);
      chk("pre_reset_nbr", 32'(b.stat_branches), 1);
      #3 reset_n = 0;
      #1;
      chk("midreset_outs", 32'(outs()), 0);
      chk("midreset_nbr", 32'(b.stat_branches), 0);
      chk("midreset_nmp", 32'(b.stat_mispredicts), 0);
      step();
      idle();
      reset_n = 1;
      exp_br = 0;
      exp_mp = 0;
      predict("post_reset_3000", 16'h3000, 0);
      predict("post_reset_3004", 16'h3004, 0);

      for (int i = 0; i < 19; i++) begin
         b.res_valid = 1;
         b.res_opcode = vt[i].op;
         b.res_nzp = vt[i].nzp;
         b.res_cc = vt[i].cc;
         b.res_pc = 16'h3010;
         b.res_pred_taken = vt[i].pt;
         step();
         chk($sformatf("vec%0d", i), 32'(outs()), 32'(vt[i].exp));
      end
      b.res_valid = 0;
      step();
      chk("matrix_nbr", 32'(b.stat_branches), 15);
      chk("matrix_nmp", 32'(b.stat_mispredicts), 6);
      chk("idle_outs", 32'(outs()), 0);
      exp_br = 15;
      exp_mp = 6;

      // index 2 counter: 01 -> 10 -> 11 -> 11
      repeat (3) begin
         br(3'b010, 3'b010, 16'h3004, 0);
         step();
      end
      predict("train_t_3004", 16'h3004, 1);
      predict("train_t_3024", 16'h3024, 1);
      br(3'b010, 3'b100, 16'h3004, 0);
      step();
      predict("train_nt1", 16'h3004, 1);
      br(3'b010, 3'b100, 16'h3004, 0);
      step();
      predict("train_nt2", 16'h3004, 0);
      br(3'b010, 3'b100, 16'h3004, 0);
      step();
      predict("train_nt3_3024", 16'h3024, 0);
      br(3'b010, 3'b010, 16'h3004, 0);
      step();
      predict("floor_sat", 16'h3004, 0);

      // counter 01: flushed taken BR still trains the BHT
      br(3'b010, 3'b010, 16'h3004, 0);
      b.flush = 1;
      b.pred_valid = 1;
      b.pred_pc = 16'h3004;
      step();
      chk("flush_outs", 32'(outs()), 0);
      chk("flush_pred", 32'(b.pred_taken), 0);
      chk("flush_nbr", 32'(b.stat_branches), 32'(exp_br));
      chk("flush_nmp", 32'(b.stat_mispredicts), 32'(exp_mp));
      b.flush = 0;
      b.pred_valid = 0;
      predict("flush_bht", 16'h3004, 1);

      br(3'b010, 3'b100, 16'h3004, 0);
      step();
      br(3'b001, 3'b001, 16'h3004, 0);
      b.pred_valid = 1;
      b.pred_pc = 16'h3024;
      step();
      chk("bypass_pred", 32'(b.pred_taken), 1);
      chk("bypass_outs", 32'(outs()), 32'hD);
      idle();
      step();
      chk("final_nbr", 32'(b.stat_branches), 32'(exp_br));
      chk("final_nmp", 32'(b.stat_mispredicts), 32'(exp_mp));

      b4.res_valid = 1;
      b4.res_opcode = 4'b0000;
      b4.res_nzp = 3'b111;
      b4.res_cc = 3'b001;
      b4.res_pc = 16'h3008;
      b4.res_pred_taken = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (i == 13) chk("sat4_nbr14", 32'(b4.stat_branches), 14);
      end
      b4.res_valid = 0;
      step();
      chk("sat4_nbr", 32'(b4.stat_branches), 15);
      chk("sat4_nmp", 32'(b4.stat_mispredicts), 15);

      $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
      $finish;
   end
endmodule
